// File: rtl/mux_2_to_1.sv
`default_nettype none
// ============================================================================
// Module   : mux_2_to_1
// Purpose  : Registered two-lane selector. A single select bit picks one of
//            two equal-width packed data lanes. The chosen lane is loaded into
//            the output register on the rising clock edge when enabled.
//            Because the output comes only from that register, glitches on
//            sel or in never reach out.
// Ports    : clk  - system clock, rising-edge active
//            rst  - asynchronous, active-high reset (out <= RESET_VAL)
//            sel  - lane select: 0 = lane 0, 1 = lane 1
//            in   - packed lanes: lane 0 = in[WIDTH-1:0],
//                   lane 1 = in[2*WIDTH-1:WIDTH]
//            en   - output-register load enable: 1 = update, 0 = hold
//            out  - registered selected lane
// Revision : 1.0 - initial release
// ============================================================================
module mux_2_to_1 #(
   parameter int              WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sel,
   input  logic [2*WIDTH-1:0]   in,
   input  logic                 en,
   output logic [WIDTH-1:0]     out
);

   // A zero-width lane has no meaning; stop elaboration instead of building
   // a degenerate register.
   if (WIDTH < 1) begin : g_width_check
      $error("mux_2_to_1: WIDTH must be >= 1");
   end

   logic [WIDTH-1:0] w_lane0;
   logic [WIDTH-1:0] w_lane1;
   logic [WIDTH-1:0] w_selected;
   logic [WIDTH-1:0] r_out;

   assign w_lane0 = in[WIDTH-1:0];
   assign w_lane1 = in[2*WIDTH-1:WIDTH];

   // Plain two-way select. An unknown sel is an illegal input, so this logic
   // does not try to propagate or resolve X.
   always_comb begin
      w_selected = w_lane0;
      if (sel) begin
         w_selected = w_lane1;
      end
   end

   // Output register. The async reset takes priority over a load that lands
   // on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out <= RESET_VAL;
      end else if (en) begin
         r_out <= w_selected;
      end
   end

   assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_mux_2_to_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_2_to_1
// Purpose  : Directed self-checking bench for mux_2_to_1. It uses one
//            default 1-bit instance and one 8-bit instance with
//            RESET_VAL = 8'hFF. Every expected value is a hand-computed
//            constant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_2_to_1;

   logic       clk;
   // 1-bit instance
   logic       rst1;
   logic       sel1;
   logic [1:0] in1;
   logic       en1;
   logic       out1;
   // 8-bit instance
   logic        rst8;
   logic        sel8;
   logic [15:0] in8;
   logic        en8;
   logic [7:0]  out8;

   int errors;
   int checks;

   mux_2_to_1 #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
   ) u_dut1 (
      .clk (clk),
      .rst (rst1),
      .sel (sel1),
      .in  (in1),
      .en  (en1),
      .out (out1)
   );

   mux_2_to_1 #(
      .WIDTH     (8),
      .RESET_VAL (8'hFF)
   ) u_dut8 (
      .clk (clk),
      .rst (rst8),
      .sel (sel8),
      .in  (in8),
      .en  (en8),
      .out (out8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] tt_exp;

   initial begin
      errors = 0;
      checks = 0;
      rst1 = 1'b1; sel1 = 1'b0; in1 = 2'b00; en1 = 1'b0;
      rst8 = 1'b1; sel8 = 1'b0; in8 = 16'h0000; en8 = 1'b0;
      #2;
      check("reset_state_w1", {7'd0, out1}, 8'h00);
      check("reset_state_w8", out8, 8'hFF);
      step();
      step();
      @(negedge clk);
      rst1 = 1'b0;
      rst8 = 1'b0;

      // Exhaustive truth table, next-edge sequence 0,1,0,1,0,0,1,1.
      tt_exp = 8'b1100_1010;
      en1 = 1'b1;
      for (int v = 0; v < 8; v++) begin
         {sel1, in1} = 3'(v);
         step();
         check($sformatf("truth_%0d", v), {7'd0, out1}, {7'd0, tt_exp[v]});
      end

      // Hold: load 1, then freeze while the inputs run through every combination.
      sel1 = 1'b0; in1 = 2'b01;
      step();
      check("hold_load", {7'd0, out1}, 8'h01);
      en1 = 1'b0;
      for (int v = 0; v < 8; v++) begin
         {sel1, in1} = 3'(v);
         step();
         check($sformatf("hold_%0d", v), {7'd0, out1}, 8'h01);
      end
      en1 = 1'b1; sel1 = 1'b1; in1 = 2'b01;
      step();
      check("hold_reenable", {7'd0, out1}, 8'h00);

      // Latency: a mid-cycle select change must not reach out before the edge.
      sel1 = 1'b0; in1 = 2'b10;
      step();
      check("lat_before", {7'd0, out1}, 8'h00);
      @(negedge clk);
      sel1 = 1'b1;
      #1;
      check("lat_between_edges", {7'd0, out1}, 8'h00);
      step();
      check("lat_after_edge", {7'd0, out1}, 8'h01);

      // Mid-run async reset with a load pending.
      sel1 = 1'b1; in1 = 2'b10; en1 = 1'b1;
      step();
      check("pre_reset_val", {7'd0, out1}, 8'h01);
      #1;
      rst1 = 1'b1;
      #1;
      check("async_reset_immediate", {7'd0, out1}, 8'h00);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("reset_hold_%0d", k), {7'd0, out1}, 8'h00);
      end
      @(negedge clk);
      rst1 = 1'b0;
      step();
      check("release_load", {7'd0, out1}, 8'h01);

      // Reset and enable on the same edge: reset wins.
      sel1 = 1'b0; in1 = 2'b10;
      step();
      check("collide_pre", {7'd0, out1}, 8'h00);
      sel1 = 1'b1; in1 = 2'b10; en1 = 1'b1;
      @(posedge clk);
      rst1 = 1'b1;
      #1;
      check("collide_reset_wins", {7'd0, out1}, 8'h00);
      @(negedge clk);
      rst1 = 1'b0;
      step();
      check("collide_release", {7'd0, out1}, 8'h01);

      // Wide lanes.
      in8 = {8'hA5, 8'h3C}; sel8 = 1'b0; en8 = 1'b1;
      step();
      check("w8_lane0", out8, 8'h3C);
      sel8 = 1'b1;
      step();
      check("w8_lane1", out8, 8'hA5);
      en8 = 1'b0; sel8 = 1'b0;
      step();
      check("w8_hold", out8, 8'hA5);
      #1;
      rst8 = 1'b1;
      #1;
      check("w8_reset", out8, 8'hFF);
      @(negedge clk);
      rst8 = 1'b0;
      step();
      check("w8_after_reset_hold", out8, 8'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
